// File: rtl/ila_trigger.sv
// ILA trigger stage: registered probe path, value/mask + edge compare, Nth-occurrence pulse.
// Optional external trigger input enabled by defining ILA_TRIG_EXT_EN.
package reg_map_pkg;
  localparam logic [31:0] R_ILA_TRIG_CTRL     = 32'h0000_0000;
  localparam logic [31:0] R_ILA_TRIG_VALUE    = 32'h0000_0004;
  localparam logic [31:0] R_ILA_TRIG_MASK     = 32'h0000_0008;
  localparam logic [31:0] R_ILA_TRIG_EDGE_EN  = 32'h0000_000C;
  localparam logic [31:0] R_ILA_TRIG_EDGE_POL = 32'h0000_0010;
  localparam logic [31:0] R_ILA_TRIG_COUNT    = 32'h0000_0014;
  localparam logic [31:0] R_ILA_TRIG_STATUS   = 32'h0000_0018;
endpackage

module ila_trigger
  import reg_map_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ILA_TRIG_EXT_EN
  input  logic             ext_trig_in,
`endif
  input  logic [WIDTH-1:0] probe_in,
  output logic [WIDTH-1:0] sample_out,
  output logic             trigger_out,
  output logic             armed,
  input  logic [31:0]      bus_addr,
  input  logic             bus_wen,
  input  logic             bus_ren,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] occ_q, occ_d;
  logic                 trig_q, trig_d;
  logic [WIDTH-1:0]     prev_q;
  logic [WIDTH-1:0]     value_q, mask_q;
  logic [WIDTH-1:0]     en_q, pol_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic wr_ctrl, wr_val, wr_mask;
  logic wr_en, wr_pol, wr_cnt;
  logic arm, disarm;
  logic lvl, edg, cond;
  logic [31:0] ctrl_rd;
  logic [CNT_WIDTH:0] occ_inc, tgt;
  logic unused_ren;

  assign unused_ren = bus_ren;

  assign wr_ctrl = bus_wen && (bus_addr == R_ILA_TRIG_CTRL);
  assign wr_val  = bus_wen && (bus_addr == R_ILA_TRIG_VALUE);
  assign wr_mask = bus_wen && (bus_addr == R_ILA_TRIG_MASK);
  assign wr_en   = bus_wen && (bus_addr == R_ILA_TRIG_EDGE_EN);
  assign wr_pol  = bus_wen && (bus_addr == R_ILA_TRIG_EDGE_POL);
  assign wr_cnt  = bus_wen && (bus_addr == R_ILA_TRIG_COUNT);
  assign arm     = wr_ctrl & bus_wdata[0];
  assign disarm  = wr_ctrl & bus_wdata[1];

  // prev_q is both the edge reference and the delayed sample
  assign lvl = ((probe_in ^ value_q) & mask_q) == '0;
  assign edg = (((~(probe_in ^ prev_q)) & en_q) == '0)
            && (((probe_in ~^ pol_q) & en_q) == en_q);

`ifdef ILA_TRIG_EXT_EN
  logic [2:0] ext_q;
  logic       ext_sel_q;
  logic       ext_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q     <= '0;
      ext_sel_q <= 1'b0;
    end else begin
      ext_q <= {ext_q[1:0], ext_trig_in};
      if (wr_ctrl) ext_sel_q <= bus_wdata[2];
    end
  end

  assign ext_rise = ext_q[1] & ~ext_q[2];
  assign cond     = (lvl & edg) | (ext_sel_q & ext_rise);
  assign ctrl_rd  = {29'b0, ext_sel_q, 2'b0};
`else
  assign cond    = lvl & edg;
  assign ctrl_rd = '0;
`endif

  assign occ_inc = {1'b0, occ_q} + 1'b1;
  assign tgt = (count_q == '0) ? {{CNT_WIDTH{1'b0}}, 1'b1}
                               : {1'b0, count_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      mask_q  <= '0;
      en_q    <= '0;
      pol_q   <= '0;
      count_q <= '0;
      prev_q  <= '0;
    end else begin
      prev_q <= probe_in;
      if (wr_val)  value_q <= bus_wdata[WIDTH-1:0];
      if (wr_mask) mask_q  <= bus_wdata[WIDTH-1:0];
      if (wr_en)   en_q    <= bus_wdata[WIDTH-1:0];
      if (wr_pol)  pol_q   <= bus_wdata[WIDTH-1:0];
      if (wr_cnt)  count_q <= bus_wdata[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      occ_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      trig_q  <= trig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    trig_d  = 1'b0;
    if (disarm) begin
      state_d = IDLE;
      occ_d   = '0;
    end else if (arm) begin
      state_d = ARMED;
      occ_d   = '0;
    end else if (state_q == ARMED) begin
      if (wr_cnt) begin
        occ_d = '0;
      end else if (cond) begin
        if (occ_inc == tgt) begin
          trig_d  = 1'b1;
          state_d = FIRED;
          occ_d   = occ_inc[CNT_WIDTH-1:0];
        end else if (!occ_inc[CNT_WIDTH]) begin
          occ_d = occ_inc[CNT_WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    bus_rdata = '0;
    unique case (1'b1)
      bus_addr == R_ILA_TRIG_CTRL:     bus_rdata = ctrl_rd;
      bus_addr == R_ILA_TRIG_VALUE:    bus_rdata = 32'(value_q);
      bus_addr == R_ILA_TRIG_MASK:     bus_rdata = 32'(mask_q);
      bus_addr == R_ILA_TRIG_EDGE_EN:  bus_rdata = 32'(en_q);
      bus_addr == R_ILA_TRIG_EDGE_POL: bus_rdata = 32'(pol_q);
      bus_addr == R_ILA_TRIG_COUNT:    bus_rdata = 32'(count_q);
      bus_addr == R_ILA_TRIG_STATUS:
        bus_rdata = {16'(occ_q), 14'b0, state_q};
      default: bus_rdata = '0;
    endcase
  end

  assign sample_out  = prev_q;
  assign trigger_out = trig_q;
  assign armed       = (state_q == ARMED);

endmodule

// File: tb/tb_ila_trigger.sv
// Randomised + directed bench for ila_trigger against a per-bit reference model.
// Build with ILA_TRIG_EXT_EN defined to also cover the external trigger path.
module tb_ila_trigger;
  import reg_map_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] probe_in;
  logic [31:0] sample_out;
  logic        trigger_out;
  logic        armed;
  logic [31:0] bus_addr;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
`ifdef ILA_TRIG_EXT_EN
  logic        ext_v;
  bit          h1, h2, h3;
`endif

  int n_chk;
  int n_fail;
  int n_pulse;

  logic [31:0] m_value, m_mask, m_en, m_pol, m_prev;
  int          m_count, m_occ, m_state;
  bit          m_trig, m_extsel;

  ila_trigger #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ILA_TRIG_EXT_EN
    .ext_trig_in (ext_v),
`endif
    .probe_in    (probe_in),
    .sample_out  (sample_out),
    .trigger_out (trigger_out),
    .armed       (armed),
    .bus_addr    (bus_addr),
    .bus_wen     (bus_wen),
    .bus_ren     (bus_ren),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_value = 0; m_mask = 0; m_en = 0; m_pol = 0; m_prev = 0;
    m_count = 0; m_occ = 0; m_state = 0; m_trig = 0; m_extsel = 0;
`ifdef ILA_TRIG_EXT_EN
    h1 = 0; h2 = 0; h3 = 0;
`endif
  endfunction

  // Bit-by-bit reading of the trigger rules
  function automatic bit model_cond(input logic [31:0] s);
    bit c = 1;
    for (int b = 0; b < 32; b++) begin
      if (m_mask[b] && s[b] != m_value[b]) c = 0;
      if (m_en[b] && (s[b] == m_prev[b] || s[b] != m_pol[b])) c = 0;
    end
`ifdef ILA_TRIG_EXT_EN
    if (m_extsel && h2 && !h3) c = 1;
`endif
    return c;
  endfunction

  function automatic void model_step(input logic [31:0] s, input bit wen,
                                     input logic [31:0] a,
                                     input logic [31:0] wd);
    bit c   = model_cond(s);
    int tgt = (m_count == 0) ? 1 : m_count;
    bit ctl = wen && a == R_ILA_TRIG_CTRL;
    m_trig = 0;
    if (ctl && wd[1]) begin
      m_state = 0; m_occ = 0;
    end else if (ctl && wd[0]) begin
      m_state = 1; m_occ = 0;
    end else if (m_state == 1) begin
      if (wen && a == R_ILA_TRIG_COUNT) m_occ = 0;
      else if (c) begin
        m_occ++;
        if (m_occ == tgt) begin
          m_trig = 1; m_state = 2;
        end
      end
    end
    if (wen) begin
      case (a)
        R_ILA_TRIG_VALUE:    m_value = wd;
        R_ILA_TRIG_MASK:     m_mask  = wd;
        R_ILA_TRIG_EDGE_EN:  m_en    = wd;
        R_ILA_TRIG_EDGE_POL: m_pol   = wd;
        R_ILA_TRIG_COUNT:    m_count = int'(wd[15:0]);
`ifdef ILA_TRIG_EXT_EN
        R_ILA_TRIG_CTRL:     m_extsel = wd[2];
`endif
        default: ;
      endcase
    end
    m_prev = s;
`ifdef ILA_TRIG_EXT_EN
    h3 = h2; h2 = h1; h1 = ext_v;
`endif
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] occ = m_occ;
    logic [31:0] st  = m_state;
    case (a)
      R_ILA_TRIG_CTRL:     return {29'b0, m_extsel, 2'b0};
      R_ILA_TRIG_VALUE:    return m_value;
      R_ILA_TRIG_MASK:     return m_mask;
      R_ILA_TRIG_EDGE_EN:  return m_en;
      R_ILA_TRIG_EDGE_POL: return m_pol;
      R_ILA_TRIG_COUNT:    return m_count;
      R_ILA_TRIG_STATUS:   return {occ[15:0], 14'b0, st[1:0]};
      default:             return 32'h0;
    endcase
  endfunction

  task automatic step(input logic [31:0] s, input bit wen,
                      input logic [31:0] a, input logic [31:0] wd);
    probe_in  = s;
    bus_wen   = wen;
    bus_addr  = a;
    bus_wdata = wd;
    @(posedge clk);
    model_step(s, wen, a, wd);
    #1;
    bus_wen = 1'b0;
    chk("sample", sample_out, m_prev);
    chk("trig", 32'(trigger_out), 32'(m_trig));
    chk("armed", 32'(armed), 32'(m_state == 1));
    if (trigger_out) n_pulse++;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] s);
    step(s, 1'b1, a, wd);
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    bus_addr = a;
    #1;
    chk(tag, bus_rdata, model_rd(a));
  endtask

  task automatic rd_all(input string tag);
    rd({tag, "_ctrl"}, R_ILA_TRIG_CTRL);
    rd({tag, "_val"},  R_ILA_TRIG_VALUE);
    rd({tag, "_mask"}, R_ILA_TRIG_MASK);
    rd({tag, "_en"},   R_ILA_TRIG_EDGE_EN);
    rd({tag, "_pol"},  R_ILA_TRIG_EDGE_POL);
    rd({tag, "_cnt"},  R_ILA_TRIG_COUNT);
    rd({tag, "_stat"}, R_ILA_TRIG_STATUS);
  endtask

  initial begin
    logic [31:0] addrs [8];
    addrs = '{R_ILA_TRIG_CTRL, R_ILA_TRIG_VALUE, R_ILA_TRIG_MASK,
              R_ILA_TRIG_EDGE_EN, R_ILA_TRIG_EDGE_POL, R_ILA_TRIG_COUNT,
              R_ILA_TRIG_STATUS, 32'h40};
    n_chk = 0; n_fail = 0; n_pulse = 0;
    rst_n = 1'b0; probe_in = '0; bus_addr = '0;
    bus_wen = 1'b0; bus_ren = 1'b0; bus_wdata = '0;
`ifdef ILA_TRIG_EXT_EN
    ext_v = 1'b0;
`endif
    model_reset();
    #12;
    chk("rst_sample", sample_out, 32'h0);
    chk("rst_trig", 32'(trigger_out), 32'h0);
    chk("rst_armed", 32'(armed), 32'h0);
    rd_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: level match
    wr(R_ILA_TRIG_MASK, 32'hFF, 32'h0);
    wr(R_ILA_TRIG_VALUE, 32'h5A, 32'h0);
    wr(R_ILA_TRIG_CTRL, 32'h1, 32'h0);
    step(32'h00, 0, 0, 0);
    chk("t1_idle", 32'(trigger_out), 32'h0);
    step(32'h5A, 0, 0, 0);
    chk("t1_trig", 32'(trigger_out), 32'h1);
    chk("t1_sample", sample_out, 32'h5A);
    step(32'h5A, 0, 0, 0);
    rd("t1_stat", R_ILA_TRIG_STATUS);
    chk("t1_state", {30'b0, bus_rdata[1:0]}, 32'h2);

    // 2: third rising edge on bit 0
    wr(R_ILA_TRIG_MASK, 32'h0, 32'h0);
    wr(R_ILA_TRIG_EDGE_EN, 32'h1, 32'h0);
    wr(R_ILA_TRIG_EDGE_POL, 32'h1, 32'h0);
    wr(R_ILA_TRIG_COUNT, 32'h3, 32'h0);
    wr(R_ILA_TRIG_CTRL, 32'h1, 32'h0);
    n_pulse = 0;
    for (int i = 0; i < 8; i++) step(32'(i % 2), 0, 0, 0);
    chk("t2_pulses", n_pulse, 1);
    rd("t2_stat", R_ILA_TRIG_STATUS);
    chk("t2_occ", {16'b0, bus_rdata[31:16]}, 32'h3);

    // 3: arm+disarm together, cond always true
    wr(R_ILA_TRIG_EDGE_EN, 32'h0, 32'h0);
    wr(R_ILA_TRIG_CTRL, 32'h3, 32'h0);
    n_pulse = 0;
    for (int i = 0; i < 4; i++) step(32'h0, 0, 0, 0);
    chk("t3_pulses", n_pulse, 0);
    rd("t3_stat", R_ILA_TRIG_STATUS);
    chk("t3_state", {30'b0, bus_rdata[1:0]}, 32'h0);

    // 4: rearm from FIRED
    wr(R_ILA_TRIG_COUNT, 32'h0, 32'h0);
    wr(R_ILA_TRIG_CTRL, 32'h1, 32'h0);
    step(32'h0, 0, 0, 0);
    step(32'h0, 0, 0, 0);
    wr(R_ILA_TRIG_CTRL, 32'h1, 32'h0);
    chk("t4_wcyc", 32'(trigger_out), 32'h0);
    rd("t4_stat", R_ILA_TRIG_STATUS);
    chk("t4_occ", {16'b0, bus_rdata[31:16]}, 32'h0);
    step(32'h0, 0, 0, 0);
    chk("t4_trig", 32'(trigger_out), 32'h1);

    // 5: reset while the pulse is on the output
    wr(R_ILA_TRIG_COUNT, 32'h3, 32'h0);
    wr(R_ILA_TRIG_VALUE, 32'h77, 32'h0);
    wr(R_ILA_TRIG_CTRL, 32'h1, 32'h0);
    for (int i = 0; i < 3; i++) step(32'h9, 0, 0, 0);
    chk("t5_pre", 32'(trigger_out), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5_trig", 32'(trigger_out), 32'h0);
    chk("t5_armed", 32'(armed), 32'h0);
    chk("t5_sample", sample_out, 32'h0);
    rd_all("t5");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ILA_TRIG_EXT_EN
    // 6: external trigger with no level match
    wr(R_ILA_TRIG_MASK, 32'hFFFF_FFFF, 32'h1234_5678);
    wr(R_ILA_TRIG_CTRL, 32'h5, 32'h1234_5678);
    n_pulse = 0;
    for (int i = 0; i < 9; i++) begin
      ext_v = (i == 1 || i == 2);
      step(32'h1234_5678, 0, 0, 0);
    end
    ext_v = 1'b0;
    chk("t6_pulses", n_pulse, 1);
    wr(R_ILA_TRIG_CTRL, 32'h2, 32'h0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] s, a, wd;
      bit wen;
      s   = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
      wen = ($urandom_range(0, 5) == 0);
      a   = addrs[$urandom_range(0, 7)];
      case (a)
        R_ILA_TRIG_CTRL:  wd = 32'($urandom_range(0, 7));
        R_ILA_TRIG_COUNT: wd = 32'($urandom_range(0, 4));
        R_ILA_TRIG_EDGE_EN: wd = $urandom & 32'h3;
        default:          wd = $urandom & 32'hF;
      endcase
      if (a == R_ILA_TRIG_COUNT && m_state == 1) a = R_ILA_TRIG_VALUE;
`ifdef ILA_TRIG_EXT_EN
      ext_v = ($urandom_range(0, 3) == 0);
`endif
      step(s, wen, a, wd);
      if (i % 7 == 0) rd("rnd_rd", addrs[$urandom_range(0, 7)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
